exe_retire: RTL and testbench

Retire stage on the consumer side of the ALU: accepts per-instruction execute results (ALU result, jump decision, destination register, branch target) through a valid/ready handshake, buffers them in a small in-order FIFO, and drives the register-file write port and the PC redirect. After a taken branch retires, it discards the wrong-path instructions already issued behind it. Sits between the execute stage and the register file / fetch unit of the core.

---
 rtl/exe_retire.sv | 160 ++++++++++++++++
 tb/tb_exe_retire.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_retire.sv
// exe_retire: retire stage behind the ALU. Buffers execute results in a small
// in-order FIFO, drives the register-file write port and issues a registered
// one-cycle PC redirect when a taken branch retires, then discards the
// SQUASH_DEPTH wrong-path instructions that follow it.
// Optional build macro RETIRE_PERF_CNT_EN enables the retired/taken counters;
// when it is undefined both counter ports are tied to zero.
module exe_retire #(
  parameter int FIFO_DEPTH   = 2,
  parameter int IMEM_ADDR_W  = 10,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   exe_valid_i,
  output logic                   exe_ready_o,
  input  logic [31:0]            exe_result_i,
  input  logic                   exe_jump_now_i,
  input  logic                   exe_is_branch_i,
  input  logic                   exe_wen_i,
  input  logic [4:0]             exe_rd_i,
  input  logic [IMEM_ADDR_W-1:0] exe_target_i,
  input  logic                   wb_ready_i,
  output logic                   rf_wen_o,
  output logic [4:0]             rf_waddr_o,
  output logic [31:0]            rf_wdata_o,
  output logic                   redirect_valid_o,
  output logic [IMEM_ADDR_W-1:0] redirect_pc_o,
  output logic                   squashing_o,
  output logic [31:0]            retired_cnt_o,
  output logic [31:0]            taken_cnt_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [2:0]    SQ_LOAD  = 3'(SQUASH_DEPTH);

  typedef enum logic {RUN, SQUASH} state_t;

  // FIFO storage (data only; never reset, qualified by count)
  logic [31:0]            result_mem [FIFO_DEPTH];
  logic                   jump_mem   [FIFO_DEPTH];
  logic                   isbr_mem   [FIFO_DEPTH];
  logic                   wen_mem    [FIFO_DEPTH];
  logic [4:0]             rd_mem     [FIFO_DEPTH];
  logic [IMEM_ADDR_W-1:0] target_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    sq_cnt, sq_cnt_nxt;
  state_t        state, state_nxt;

  logic push, pop, taken_pop, head_valid, head_taken, head_wen;

  assign exe_ready_o = (count != FULL_CNT) && n_reset;
  assign push        = exe_valid_i && exe_ready_o;
  assign head_valid  = (count != '0);
  assign head_wen    = wen_mem[rd_ptr];
  assign head_taken  = isbr_mem[rd_ptr] && jump_mem[rd_ptr];
  assign squashing_o = (state == SQUASH);

  // write port: only the RUN state commits, and only when the RF can take it
  assign rf_wen_o   = (state == RUN) && head_valid && head_wen && wb_ready_i;
  assign rf_waddr_o = rf_wen_o ? rd_mem[rd_ptr]     : 5'd0;
  assign rf_wdata_o = rf_wen_o ? result_mem[rd_ptr] : 32'd0;

  // capture the incoming execute result at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr] <= exe_result_i;
      jump_mem[wr_ptr]   <= exe_jump_now_i;
      isbr_mem[wr_ptr]   <= exe_is_branch_i;
      wen_mem[wr_ptr]    <= exe_wen_i;
      rd_mem[wr_ptr]     <= exe_rd_i;
      target_mem[wr_ptr] <= exe_target_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // next-state, pop decision and squash bookkeeping
  always_comb begin
    state_nxt  = state;
    sq_cnt_nxt = sq_cnt;
    pop        = 1'b0;
    taken_pop  = 1'b0;
    case (state)
      RUN: begin
        if (head_valid) begin
          pop = !head_wen || wb_ready_i;
          if (pop && head_taken) begin
            taken_pop  = 1'b1;
            sq_cnt_nxt = SQ_LOAD;
            if (SQ_LOAD != 3'd0) state_nxt = SQUASH;
          end
        end
      end
      SQUASH: begin
        if (head_valid) begin
          pop        = 1'b1;
          sq_cnt_nxt = sq_cnt - 3'd1;
          if (sq_cnt <= 3'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state, squash counter and registered redirect
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state            <= RUN;
      sq_cnt           <= 3'd0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      state            <= state_nxt;
      sq_cnt           <= sq_cnt_nxt;
      redirect_valid_o <= taken_pop;
      if (taken_pop) redirect_pc_o <= target_mem[rd_ptr];
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] retired_cnt, taken_cnt;

  // count architecturally retired instructions and taken branches
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      retired_cnt <= 32'd0;
      taken_cnt   <= 32'd0;
    end else begin
      if (pop && (state == RUN)) retired_cnt <= retired_cnt + 32'd1;
      if (taken_pop)             taken_cnt   <= taken_cnt + 32'd1;
    end
  end

  assign retired_cnt_o = retired_cnt;
  assign taken_cnt_o   = taken_cnt;
`else
  assign retired_cnt_o = 32'd0;
  assign taken_cnt_o   = 32'd0;
`endif

endmodule

// File: tb/tb_exe_retire.sv
// Directed testbench for exe_retire (FIFO_DEPTH=2, SQUASH_DEPTH=2).
module tb_exe_retire;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          exe_valid_i, exe_ready_o;
  logic [31:0]   exe_result_i;
  logic          exe_jump_now_i, exe_is_branch_i, exe_wen_i;
  logic [4:0]    exe_rd_i;
  logic [AW-1:0] exe_target_i;
  logic          wb_ready_i;
  logic          rf_wen_o;
  logic [4:0]    rf_waddr_o;
  logic [31:0]   rf_wdata_o;
  logic          redirect_valid_o;
  logic [AW-1:0] redirect_pc_o;
  logic          squashing_o;
  logic [31:0]   retired_cnt_o, taken_cnt_o;

  int checks   = 0;
  int failures = 0;

  exe_retire #(.FIFO_DEPTH(2), .IMEM_ADDR_W(AW), .SQUASH_DEPTH(2)) dut (
    .clk(clk), .n_reset(n_reset),
    .exe_valid_i(exe_valid_i), .exe_ready_o(exe_ready_o),
    .exe_result_i(exe_result_i), .exe_jump_now_i(exe_jump_now_i),
    .exe_is_branch_i(exe_is_branch_i), .exe_wen_i(exe_wen_i),
    .exe_rd_i(exe_rd_i), .exe_target_i(exe_target_i),
    .wb_ready_i(wb_ready_i),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .squashing_o(squashing_o),
    .retired_cnt_o(retired_cnt_o), .taken_cnt_o(taken_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] res, input logic jmp,
                       input logic br, input logic wen, input logic [4:0] rd,
                       input logic [AW-1:0] tgt);
    exe_valid_i     = v;
    exe_result_i    = res;
    exe_jump_now_i  = jmp;
    exe_is_branch_i = br;
    exe_wen_i       = wen;
    exe_rd_i        = rd;
    exe_target_i    = tgt;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, '0);
  endtask

  task automatic test_reset();
    n_reset = 1'b0; wb_ready_i = 1'b0; idle();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({exe_ready_o, rf_wen_o, redirect_valid_o, squashing_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000",
        {exe_ready_o, rf_wen_o, redirect_valid_o, squashing_o});
    end
    checks++;
    if (redirect_pc_o !== '0 || retired_cnt_o !== 32'd0 || taken_cnt_o !== 32'd0) begin
      failures++; $display("FAIL reset_values pc=%h ret=%0d tkn=%0d exp=0",
        redirect_pc_o, retired_cnt_o, taken_cnt_o);
    end
    n_reset = 1'b1; #1;
    checks++;
    if (exe_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", exe_ready_o);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    wb_ready_i = 1'b1;
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 5'd3, '0); #1;
    checks++;
    if (exe_ready_o !== 1'b1) begin
      failures++; $display("FAIL basic_ready got=%b exp=1", exe_ready_o);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (rf_wen_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h5) begin
      failures++; $display("FAIL basic_write got=%b/%0d/%h exp=1/3/00000005",
        rf_wen_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk); #1;
    checks++;
    if (rf_wen_o !== 1'b0 || exe_ready_o !== 1'b1) begin
      failures++; $display("FAIL basic_drain wen=%b ready=%b exp=0/1", rf_wen_o, exe_ready_o);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    wb_ready_i = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 5'd1, '0);
    @(negedge clk);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 5'd2, '0);
    @(negedge clk);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 5'd5, '0); #1;
    checks++;
    if (exe_ready_o !== 1'b0) begin
      failures++; $display("FAIL bp_full_ready got=%b exp=0", exe_ready_o);
    end
    @(negedge clk);
    idle(); wb_ready_i = 1'b1; #1;
    checks++;
    if (rf_wen_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h11) begin
      failures++; $display("FAIL bp_first got=%b/%0d/%h exp=1/1/00000011",
        rf_wen_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk); #1;
    checks++;
    if (rf_wen_o !== 1'b1 || rf_waddr_o !== 5'd2 || rf_wdata_o !== 32'h22) begin
      failures++; $display("FAIL bp_second got=%b/%0d/%h exp=1/2/00000022",
        rf_wen_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk); #1;
    checks++;
    if (rf_wen_o !== 1'b0) begin
      failures++; $display("FAIL bp_refused_not_stored got=%b exp=0", rf_wen_o);
    end
  endtask

  task automatic test_squash();
    @(negedge clk);
    wb_ready_i = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 10'h040);
    @(negedge clk);
    drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 5'd4, '0); #1;
    checks++;
    if (rf_wen_o !== 1'b0 || squashing_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      failures++; $display("FAIL sq_branch_head wen=%b sq=%b rv=%b exp=0/0/0",
        rf_wen_o, squashing_o, redirect_valid_o);
    end
    @(negedge clk);
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 5'd5, '0); #1;
    checks++;
    if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 10'h040) begin
      failures++; $display("FAIL sq_redirect rv=%b pc=%h exp=1/040", redirect_valid_o, redirect_pc_o);
    end
    checks++;
    if (squashing_o !== 1'b1 || rf_wen_o !== 1'b0) begin
      failures++; $display("FAIL sq_first_drop sq=%b wen=%b exp=1/0", squashing_o, rf_wen_o);
    end
    @(negedge clk);
    drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 5'd6, '0); #1;
    checks++;
    if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 10'h040 ||
        squashing_o !== 1'b1 || rf_wen_o !== 1'b0) begin
      failures++; $display("FAIL sq_second_drop rv=%b pc=%h sq=%b wen=%b exp=0/040/1/0",
        redirect_valid_o, redirect_pc_o, squashing_o, rf_wen_o);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (squashing_o !== 1'b0 || rf_wen_o !== 1'b1 || rf_waddr_o !== 5'd6 ||
        rf_wdata_o !== 32'h66) begin
      failures++; $display("FAIL sq_resume sq=%b wen=%b rd=%0d data=%h exp=0/1/6/00000066",
        squashing_o, rf_wen_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_untaken();
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 10'h3AA);
    @(negedge clk);
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 5'd7, '0);
    @(negedge clk);
    idle(); #1;
    checks++;
    if (redirect_valid_o !== 1'b0 || squashing_o !== 1'b0 || redirect_pc_o !== 10'h040) begin
      failures++; $display("FAIL untaken_no_redirect rv=%b sq=%b pc=%h exp=0/0/040",
        redirect_valid_o, squashing_o, redirect_pc_o);
    end
    checks++;
    if (rf_wen_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'h77) begin
      failures++; $display("FAIL untaken_follow got=%b/%0d/%h exp=1/7/00000077",
        rf_wen_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_perf();
    logic [31:0] exp_ret, exp_tkn;
`ifdef RETIRE_PERF_CNT_EN
    exp_ret = 32'd7; exp_tkn = 32'd1;
`else
    exp_ret = 32'd0; exp_tkn = 32'd0;
`endif
    #1;
    checks++;
    if (retired_cnt_o !== exp_ret || taken_cnt_o !== exp_tkn) begin
      failures++; $display("FAIL perf_counts ret=%0d tkn=%0d exp=%0d/%0d",
        retired_cnt_o, taken_cnt_o, exp_ret, exp_tkn);
    end
  endtask

  task automatic test_reset_mid_squash();
    @(negedge clk);
    wb_ready_i = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 10'h155);
    @(negedge clk);
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 5'd9, '0);
    @(negedge clk);
    idle(); #1;
    checks++;
    if (squashing_o !== 1'b1 || redirect_valid_o !== 1'b1) begin
      failures++; $display("FAIL rms_pre sq=%b rv=%b exp=1/1", squashing_o, redirect_valid_o);
    end
    n_reset = 1'b0; #1;
    checks++;
    if ({exe_ready_o, rf_wen_o, redirect_valid_o, squashing_o} !== 4'b0000 ||
        redirect_pc_o !== '0 || retired_cnt_o !== 32'd0 || taken_cnt_o !== 32'd0) begin
      failures++; $display("FAIL rms_async flags=%b pc=%h ret=%0d tkn=%0d exp=0000/000/0/0",
        {exe_ready_o, rf_wen_o, redirect_valid_o, squashing_o}, redirect_pc_o,
        retired_cnt_o, taken_cnt_o);
    end
    @(negedge clk);
    n_reset = 1'b1; #1;
    checks++;
    if (exe_ready_o !== 1'b1 || rf_wen_o !== 1'b0 || squashing_o !== 1'b0) begin
      failures++; $display("FAIL rms_empty ready=%b wen=%b sq=%b exp=1/0/0",
        exe_ready_o, rf_wen_o, squashing_o);
    end
    @(negedge clk);
    drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 5'd10, '0);
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rf_wen_o !== 1'b1 || rf_waddr_o !== 5'd10 || rf_wdata_o !== 32'hAA ||
        redirect_valid_o !== 1'b0) begin
      failures++; $display("FAIL rms_new_write got=%b/%0d/%h rv=%b exp=1/10/000000aa/0",
        rf_wen_o, rf_waddr_o, rf_wdata_o, redirect_valid_o);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_squash();
    test_untaken();
    test_perf();
    test_reset_mid_squash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
